// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
// Contents: state encoding, bus widths, port ids, request payload struct, 32-bit mux helper.
package mem_port_arbiter_pkg;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STARVE_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Request payload presented to the memory by the winning port.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  // 2:1 word mux: sel=0 -> a0, sel=1 -> a1.
  function automatic logic [31:0] mux32(input logic sel, input logic [31:0] a0,
                                        input logic [31:0] a1);
    return sel ? a1 : a0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline (fetch + load/store ports), the arbiter and the memory.
// slave  : arbiter view (takes requests and mem_rdata, drives grants/responses/mem strobes/stalls)
// master : pipeline + memory view (opposite directions)
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

endinterface

// File: rtl/mem_lat_timer.sv
// Memory latency timer: loads 1 on a grant, counts up to MEM_LAT, flags the response cycle.
// Ports: clk, rst (sync, active-high), load (grant this cycle), resp_c (count == MEM_LAT).
module mem_lat_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic resp_c
);

  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MEM_LAT);

  logic [LAT_W-1:0] lat_cnt;

  // A grant in the response cycle restarts the count, giving back-to-back accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= '0;
    end else if (load) begin
      lat_cnt <= LAT_W'(1);
    end else if (resp_c) begin
      lat_cnt <= '0;
    end else if (lat_cnt != '0) begin
      lat_cnt <= lat_cnt + LAT_W'(1);
    end
  end

  assign resp_c = (lat_cnt == LAT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data has priority; after STARVE_MAX data grants with fetch waiting, fetch is forced through.
// Ports: clk, rst (sync, active-high), bus (slave modport: fetch port, data port,
//        memory strobes, stall_if/stall_mem). Grants and mem_* are combinational.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_e                state_q, state_d;
  logic                  resp_c;
  logic                  free_c;
  logic                  gnt_i_c, gnt_d_c, gnt_c;
  logic                  win_c;
  logic                  rvalid_i_c, rvalid_d_c;
  logic                  d_we_q;
  logic [STARVE_W-1:0]   starve_cnt;
  mem_req_t              req_w_c;

  mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (gnt_c),
    .resp_c (resp_c)
  );

  // Port is available when idle or on the response cycle of the current access.
  assign free_c = (state_q == IDLE) || resp_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration and next state.
  always_comb begin
    state_d = state_q;
    gnt_i_c = 1'b0;
    gnt_d_c = 1'b0;
    if (!rst && free_c) begin
      if (bus.d_req && !(bus.if_req && (starve_cnt == STARVE_LIM))) begin
        gnt_d_c = 1'b1;
      end else if (bus.if_req) begin
        gnt_i_c = 1'b1;
      end
    end
    if (gnt_d_c) begin
      state_d = BUSY_D;
    end else if (gnt_i_c) begin
      state_d = BUSY_I;
    end else if (resp_c) begin
      state_d = IDLE;
    end
  end

  assign gnt_c = gnt_i_c | gnt_d_c;

  // Count data grants that pass over a waiting fetch; saturate at the limit.
  always_ff @(posedge clk) begin
    if (rst || !bus.if_req || gnt_i_c) begin
      starve_cnt <= '0;
    end else if (gnt_d_c && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Remember whether the outstanding data access is a store so its completion returns 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_we_q <= 1'b0;
    end else if (gnt_d_c) begin
      d_we_q <= bus.d_we;
    end
  end

  // Winning request payload.
  assign win_c = gnt_d_c ? PORT_D : PORT_I;

  always_comb begin
    req_w_c = '0;
    if (win_c == PORT_D) begin
      req_w_c.we    = bus.d_we;
      req_w_c.addr  = bus.d_addr;
      req_w_c.wdata = bus.d_wdata;
    end else begin
      req_w_c.addr  = bus.if_addr;
    end
  end

  assign rvalid_i_c = !rst && (state_q == BUSY_I) && resp_c;
  assign rvalid_d_c = !rst && (state_q == BUSY_D) && resp_c;

  assign bus.if_gnt    = gnt_i_c;
  assign bus.d_gnt     = gnt_d_c;
  assign bus.if_rvalid = rvalid_i_c;
  assign bus.d_rvalid  = rvalid_d_c;
  assign bus.if_rdata  = mux32(rvalid_i_c, 32'd0, bus.mem_rdata);
  assign bus.d_rdata   = mux32(rvalid_d_c && !d_we_q, 32'd0, bus.mem_rdata);

  // Memory strobes only ever assert in a grant cycle.
  assign bus.mem_en    = gnt_c;
  assign bus.mem_we    = gnt_c & req_w_c.we;
  assign bus.mem_addr  = mux32(gnt_c, 32'd0, req_w_c.addr);
  assign bus.mem_wdata = mux32(gnt_c, 32'd0, req_w_c.wdata);

  assign bus.stall_if  = !rst && bus.if_req && !rvalid_i_c;
  assign bus.stall_mem = !rst && (bus.d_req || (state_q == BUSY_D)) && !rvalid_d_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: u1 runs with MEM_LAT=1, u3 with MEM_LAT=3.
// Each bus has a small memory model whose word at address a is 0xA000_0000 | a unless stored.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if b1();
  mem_port_arbiter_if b3();

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u1 (.clk(clk), .rst(rst1), .bus(b1));
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u3 (.clk(clk), .rst(rst3), .bus(b3));

  localparam logic [31:0] STV_ADDR [7] = '{32'h200, 32'h204, 32'h208, 32'h20C,
                                          32'h20,  32'h210, 32'h214};

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Memory model, latency 1, one remembered store.
  logic [31:0] pipe1 = 32'd0;
  logic        st_v  = 1'b0;
  logic [31:0] st_a  = 32'd0;
  logic [31:0] st_d  = 32'd0;
  always @(posedge clk) begin
    if (b1.mem_en) pipe1 <= (st_v && (st_a == b1.mem_addr)) ? st_d : word(b1.mem_addr);
    else           pipe1 <= 32'hBAD0_0001;
    if (b1.mem_en && b1.mem_we) begin
      st_v <= 1'b1;
      st_a <= b1.mem_addr;
      st_d <= b1.mem_wdata;
    end
  end
  assign b1.mem_rdata = pipe1;

  // Memory model, latency 3, read-only.
  logic [31:0] p3a = 32'd0, p3b = 32'd0, p3c = 32'd0;
  always @(posedge clk) begin
    p3a <= b3.mem_en ? word(b3.mem_addr) : 32'hBAD0_0003;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign b3.mem_rdata = p3c;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.d_addr = '0;   b1.d_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0;
    b3.d_addr = '0;   b3.d_wdata = '0;
  endtask

  task automatic test_reset();
    logic [7:0] o1, o3;
    idle_inputs();
    rst1 = 1'b1; rst3 = 1'b1;
    b1.if_req = 1'b1; b1.d_req = 1'b1; b3.if_req = 1'b1; b3.d_req = 1'b1;
    @(negedge clk);
    o1 = {b1.if_gnt, b1.d_gnt, b1.if_rvalid, b1.d_rvalid, b1.mem_en, b1.mem_we,
          b1.stall_if, b1.stall_mem};
    o3 = {b3.if_gnt, b3.d_gnt, b3.if_rvalid, b3.d_rvalid, b3.mem_en, b3.mem_we,
          b3.stall_if, b3.stall_mem};
    n_checks++;
    if (o1 !== 8'h00) begin n_fail++; $display("FAIL reset_outs_u1: got %b want 00000000", o1); end
    n_checks++;
    if (o3 !== 8'h00) begin n_fail++; $display("FAIL reset_outs_u3: got %b want 00000000", o3); end
    step();
    idle_inputs();
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b1.mem_en, b1.mem_we, b1.if_rvalid, b1.d_rvalid, b1.mem_addr} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_idle_u1: en=%b we=%b irv=%b drv=%b addr=%h want all 0",
               b1.mem_en, b1.mem_we, b1.if_rvalid, b1.d_rvalid, b1.mem_addr);
    end
    step();
  endtask

  task automatic test_fetch();
    logic g, rv, st;
    for (int i = 0; i < 5; i++) begin
      b1.if_req  = (i < 3);
      b1.if_addr = (i < 3) ? 32'(i * 4) : 32'd0;
      g  = (i < 3);
      rv = (i >= 1) && (i <= 3);
      st = (i == 0);
      @(negedge clk);
      n_checks++;
      if ({b1.if_gnt, b1.if_rvalid, b1.stall_if, b1.mem_en, b1.mem_we} !== {g, rv, st, g, 1'b0}) begin
        n_fail++;
        $display("FAIL fetch_ctl cyc %0d: gnt/rv/stall/en/we=%b%b%b%b%b want %b%b%b%b0", i,
                 b1.if_gnt, b1.if_rvalid, b1.stall_if, b1.mem_en, b1.mem_we, g, rv, st, g);
      end
      n_checks++;
      if (b1.mem_addr !== (g ? 32'(i * 4) : 32'd0)) begin
        n_fail++; $display("FAIL fetch_addr cyc %0d: got %h", i, b1.mem_addr);
      end
      if (rv) begin
        n_checks++;
        if (b1.if_rdata !== 32'hA000_0000 + 32'((i - 1) * 4)) begin
          n_fail++; $display("FAIL fetch_rdata cyc %0d: got %h", i, b1.if_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_contention();
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h100;
    b1.if_req = 1'b1; b1.if_addr = 32'h0;
    @(negedge clk);
    n_checks++;
    if ({b1.d_gnt, b1.if_gnt, b1.mem_addr} !== {2'b10, 32'h100}) begin
      n_fail++; $display("FAIL cont_c0: dg=%b ig=%b addr=%h want 1 0 00000100",
                         b1.d_gnt, b1.if_gnt, b1.mem_addr);
    end
    step();
    b1.d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b1.if_gnt, b1.mem_addr, b1.d_rvalid, b1.d_rdata} !== {1'b1, 32'h0, 1'b1, 32'hA000_0100}) begin
      n_fail++; $display("FAIL cont_c1: ig=%b addr=%h drv=%b drd=%h want 1 0 1 a0000100",
                         b1.if_gnt, b1.mem_addr, b1.d_rvalid, b1.d_rdata);
    end
    step();
    b1.if_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b1.if_rvalid, b1.if_rdata, b1.d_rvalid, b1.mem_en} !== {1'b1, 32'hA000_0000, 2'b00}) begin
      n_fail++; $display("FAIL cont_c2: irv=%b ird=%h drv=%b en=%b want 1 a0000000 0 0",
                         b1.if_rvalid, b1.if_rdata, b1.d_rvalid, b1.mem_en);
    end
    step();
  endtask

  task automatic test_starvation();
    logic [6:0] exp_d = 7'b1101111;
    logic [6:0] exp_i = 7'b0010000;
    logic       got_d, got_i;
    int         dn = 0;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h200;
    b1.if_req = 1'b1; b1.if_addr = 32'h20;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      got_d = b1.d_gnt;
      got_i = b1.if_gnt;
      n_checks++;
      if ({got_d, got_i, b1.mem_addr} !== {exp_d[i], exp_i[i], STV_ADDR[i]}) begin
        n_fail++; $display("FAIL starve_gnt cyc %0d: dg=%b ig=%b addr=%h want %b %b %h", i,
                           got_d, got_i, b1.mem_addr, exp_d[i], exp_i[i], STV_ADDR[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (u1.starve_cnt !== 3'd4) begin
          n_fail++; $display("FAIL starve_sat: got %0d want 4", u1.starve_cnt);
        end
      end
      step();
      if (got_d) begin
        dn++;
        b1.d_addr = b1.d_addr + 32'd4;
        if (dn == 6) b1.d_req = 1'b0;
      end
      if (got_i) b1.if_req = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({u1.starve_cnt, b1.d_gnt, b1.if_gnt, b1.d_rvalid, b1.d_rdata} !==
        {3'd0, 2'b00, 1'b1, 32'hA000_0214}) begin
      n_fail++; $display("FAIL starve_end: cnt=%0d dg=%b ig=%b drv=%b drd=%h want 0 0 0 1 a0000214",
                         u1.starve_cnt, b1.d_gnt, b1.if_gnt, b1.d_rvalid, b1.d_rdata);
    end
    step();
  endtask

  task automatic test_store_load();
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h40; b1.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if ({b1.d_gnt, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata} !==
        {3'b111, 32'h40, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL store_issue: g/en/we=%b%b%b addr=%h wd=%h want 111 40 deadbeef",
                         b1.d_gnt, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata);
    end
    step();
    b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_wdata = 32'd0;
    @(negedge clk);
    n_checks++;
    if ({b1.d_rvalid, b1.mem_en, b1.mem_we, b1.stall_mem, b1.d_rdata} !== {4'b1000, 32'd0}) begin
      n_fail++; $display("FAIL store_done: rv/en/we/stall=%b%b%b%b rd=%h want 1000 0",
                         b1.d_rvalid, b1.mem_en, b1.mem_we, b1.stall_mem, b1.d_rdata);
    end
    step();
    b1.d_req = 1'b1; b1.d_addr = 32'h40;
    @(negedge clk);
    n_checks++;
    if ({b1.d_gnt, b1.mem_we} !== 2'b10) begin
      n_fail++; $display("FAIL load_issue: g=%b we=%b want 1 0", b1.d_gnt, b1.mem_we);
    end
    step();
    b1.d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b1.d_rvalid, b1.d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL load_back: rv=%b rd=%h want 1 deadbeef", b1.d_rvalid, b1.d_rdata);
    end
    step();
  endtask

  task automatic test_lat3_fetch();
    logic g, rv, st;
    for (int i = 0; i < 8; i++) begin
      b3.if_req  = (i <= 3);
      b3.if_addr = (i == 0) ? 32'h8 : 32'hC;
      g  = (i == 0) || (i == 3);
      rv = (i == 3) || (i == 6);
      st = (i < 3);
      @(negedge clk);
      n_checks++;
      if ({b3.if_gnt, b3.if_rvalid, b3.stall_if, b3.mem_en} !== {g, rv, st, g}) begin
        n_fail++; $display("FAIL lat3_ctl cyc %0d: gnt/rv/stall/en=%b%b%b%b want %b%b%b%b", i,
                           b3.if_gnt, b3.if_rvalid, b3.stall_if, b3.mem_en, g, rv, st, g);
      end
      if (rv) begin
        n_checks++;
        if (b3.if_rdata !== ((i == 3) ? 32'hA000_0008 : 32'hA000_000C)) begin
          n_fail++; $display("FAIL lat3_rdata cyc %0d: got %h", i, b3.if_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_inflight();
    logic [7:0] o3;
    int         dv_cnt = 0;
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if (b3.d_gnt !== 1'b1) begin n_fail++; $display("FAIL rstf_gnt: got %b want 1", b3.d_gnt); end
    step();
    b3.d_req = 1'b0; rst3 = 1'b1; b3.if_req = 1'b1; b3.if_addr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o3 = {b3.if_gnt, b3.d_gnt, b3.if_rvalid, b3.d_rvalid, b3.mem_en, b3.mem_we,
            b3.stall_if, b3.stall_mem};
      n_checks++;
      if ({o3, b3.mem_addr} !== 40'd0) begin
        n_fail++; $display("FAIL rstf_hold cyc %0d: outs=%b addr=%h want 0", i, o3, b3.mem_addr);
      end
      step();
    end
    rst3 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b3.if_gnt, b3.mem_en, b3.d_rvalid, b3.stall_mem, b3.mem_addr} !== {4'b1100, 32'h0}) begin
      n_fail++; $display("FAIL rstf_first: ig/en/drv/stm=%b%b%b%b addr=%h want 1100 0",
                         b3.if_gnt, b3.mem_en, b3.d_rvalid, b3.stall_mem, b3.mem_addr);
    end
    step();
    b3.if_req = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (b3.d_rvalid) dv_cnt++;
      if (i == 3) begin
        n_checks++;
        if ({b3.if_rvalid, b3.if_rdata} !== {1'b1, 32'hA000_0000}) begin
          n_fail++; $display("FAIL rstf_fetch: rv=%b rd=%h want 1 a0000000", b3.if_rvalid, b3.if_rdata);
        end
      end
      step();
    end
    n_checks++;
    if (dv_cnt !== 0) begin n_fail++; $display("FAIL rstf_no_drv: got %0d d_rvalid want 0", dv_cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_starvation();
    test_store_load();
    test_lat3_fetch();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
